// File: rtl/data_mem_resp_if.sv
// Core-side data-memory request/response bundle: the request handshake with
// we/size/unsign/addr/wdata, and the valid/ready response with rdata/err.
interface data_mem_resp_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsign;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsign, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsign, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: one load/store at a time into a synchronous SRAM.
// Optional MEM_ALIGN_CHECK_EN turns misaligned half/word accesses into error responses.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for a request; SRAM strobed combinationally on accept
// S_ACCESS | store write cycle after the strobe
// S_WAIT   | load waiting out SRAM_LAT; rdata registered on terminal count
// S_RESP   | response held until resp_ready
module data_mem_resp #(
    parameter int SRAM_LAT = 1,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_resp_if.slave    bus,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] LAT_TC = 2'(SRAM_LAT);

    logic [1:0]  state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        unsign_q, unsign_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        misaligned;
    logic [3:0]  store_we;
    logic [31:0] store_wdata;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q, err_d;

    // reserved size 3 is checked like a word
    assign misaligned = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    assign bus.resp_err = err_q;
`else
    assign misaligned   = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign accept         = bus.req_valid && bus.req_ready && !reset;

    always_comb begin
        store_we    = 4'hF;
        store_wdata = bus.req_wdata;
        case (bus.req_size)
            2'd0: begin
                store_we    = 4'b0001 << bus.req_addr[1:0];
                store_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                store_we    = 4'b0011 << {bus.req_addr[1], 1'b0};
                store_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                store_we    = 4'hF;
                store_wdata = bus.req_wdata;
            end
        endcase
    end

    always_comb begin
        lane_b = sram_rdata[7:0];
        case (off_q)
            2'd0:    lane_b = sram_rdata[7:0];
            2'd1:    lane_b = sram_rdata[15:8];
            2'd2:    lane_b = sram_rdata[23:16];
            default: lane_b = sram_rdata[31:24];
        endcase
        lane_h = off_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
        case (size_q)
            2'd0:    load_ext = unsign_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'd1:    load_ext = unsign_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = sram_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        unsign_d   = unsign_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
`ifdef MEM_ALIGN_CHECK_EN
        err_d      = err_q;
`endif
        sram_en    = 1'b0;
        sram_we    = 4'h0;
        sram_addr  = '0;
        sram_wdata = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    size_d    = bus.req_size;
                    unsign_d  = bus.req_unsign;
                    off_d     = bus.req_addr[1:0];
                    rdata_d   = 32'h0;
                    cnt_d     = 2'd0;
                    sram_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
`ifdef MEM_ALIGN_CHECK_EN
                    err_d     = misaligned;
`endif
                    if (misaligned) begin
                        state_d = S_RESP;
                    end else begin
                        sram_en = 1'b1;
                        if (bus.req_we) begin
                            sram_we    = store_we;
                            sram_wdata = store_wdata;
                            state_d    = S_ACCESS;
                        end else begin
                            // the strobe cycle itself is count 1
                            cnt_d   = 2'd1;
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
            end
            S_WAIT: begin
                if (cnt_q == LAT_TC) begin
                    rdata_d = load_ext;
                    cnt_d   = 2'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = 2'(cnt_q + 2'd1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            size_q   <= 2'd0;
            unsign_q <= 1'b0;
            off_q    <= 2'd0;
            cnt_q    <= 2'd0;
            rdata_q  <= 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            unsign_q <= unsign_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
`ifdef MEM_ALIGN_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: main instance at SRAM_LAT=1 plus two
// read-only instances at SRAM_LAT=2/3 for the latency sweep.
module tb_data_mem_resp;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_resp_if #(.ADDR_W(32)) bus  ();
    data_mem_resp_if #(.ADDR_W(32)) bus2 ();
    data_mem_resp_if #(.ADDR_W(32)) bus3 ();

    logic        en1, en2, en3;
    logic [3:0]  we1, we2, we3;
    logic [31:0] ad1, ad2, ad3;
    logic [31:0] wd1, wd2, wd3;
    logic [31:0] rd1, rd2, rd3;

    data_mem_resp #(.SRAM_LAT(1), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .sram_en(en1), .sram_we(we1), .sram_addr(ad1), .sram_wdata(wd1), .sram_rdata(rd1));
    data_mem_resp #(.SRAM_LAT(2), .ADDR_W(32)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave),
        .sram_en(en2), .sram_we(we2), .sram_addr(ad2), .sram_wdata(wd2), .sram_rdata(rd2));
    data_mem_resp #(.SRAM_LAT(3), .ADDR_W(32)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave),
        .sram_en(en3), .sram_we(we3), .sram_addr(ad3), .sram_wdata(wd3), .sram_rdata(rd3));

    // SRAM models: data is valid only in the one cycle LAT after the read strobe
    function automatic logic [31:0] sram_word(input logic [31:0] a);
        case (a)
            32'h80:  return 32'h8899AABB;
            32'h40:  return 32'hDEADBEEF;
            32'h10:  return 32'hF00D1234;
            default: return 32'h00000000;
        endcase
    endfunction

    logic [2:0]  sh1, sh2, sh3;
    logic [31:0] ra1, ra2, ra3;
    always @(posedge clk) begin
        if (reset) begin
            sh1 <= '0; sh2 <= '0; sh3 <= '0;
            ra1 <= '0; ra2 <= '0; ra3 <= '0;
        end else begin
            sh1 <= {sh1[1:0], en1 && (we1 == 4'h0)};
            sh2 <= {sh2[1:0], en2 && (we2 == 4'h0)};
            sh3 <= {sh3[1:0], en3 && (we3 == 4'h0)};
            if (en1) ra1 <= ad1;
            if (en2) ra2 <= ad2;
            if (en3) ra3 <= ad3;
        end
    end
    assign rd1 = sh1[0] ? sram_word(ra1) : 32'h5A5A5A5A;
    assign rd2 = sh2[1] ? sram_word(ra2) : 32'h5A5A5A5A;
    assign rd3 = sh3[2] ? sram_word(ra3) : 32'h5A5A5A5A;

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int          t_lat, t_en;
    logic        t_got, t_err;
    logic [31:0] t_rd, t_ad, t_wd;
    logic [3:0]  t_we;
    logic [1:0]  t_post;

    // one request on the main instance with resp_ready high
    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsign = uns; bus.req_addr = a; bus.req_wdata = wd;
        #1;
        t_en = int'(en1); t_we = we1; t_wd = wd1; t_ad = ad1;
        @(posedge clk);
        t_lat = 0; t_got = 1'b0;
        for (int i = 1; i <= 20 && !t_got; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                t_got = 1'b1; t_lat = i;
            end else begin
                t_en += int'(en1);
            end
        end
        t_rd = bus.resp_rdata; t_err = bus.resp_err;
        @(posedge clk);
        @(negedge clk);
        t_post = {bus.resp_valid, bus.req_ready};
    endtask

    logic        got;
    int          l1, l2, l3;
    logic [31:0] s1, s2, s3;

    initial begin
        reset = 1'b1;
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsign = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 1;
        bus2.req_valid = 0; bus2.req_we = 0; bus2.req_size = 1; bus2.req_unsign = 1;
        bus2.req_addr = 32'h12; bus2.req_wdata = 0; bus2.resp_ready = 1;
        bus3.req_valid = 0; bus3.req_we = 0; bus3.req_size = 1; bus3.req_unsign = 1;
        bus3.req_addr = 32'h12; bus3.req_wdata = 0; bus3.resp_ready = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_sram_en",    32'(en1), 32'd0);
        chk("rst_sram_we",    32'(we1), 32'd0);
        chk("rst_sram_addr",  ad1, 32'd0);
        chk("rst_sram_wdata", wd1, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err",   32'(bus.resp_err), 32'd0);
        reset = 1'b0;

        // ld.b 0x83 signed / unsigned
        txn(1'b0, 2'd0, 1'b0, 32'h83, 32'h0);
        chk("ldb_addr", t_ad, 32'h80);
        chk("ldb_we", 32'(t_we), 32'd0);
        chk("ldb_en_pulses", 32'(t_en), 32'd1);
        chk("ldb_lat", 32'(t_lat), 32'd2);
        chk("ldb_rdata", t_rd, 32'hFFFFFF88);
        chk("ldb_err", 32'(t_err), 32'd0);
        chk("ldb_post", 32'(t_post), 32'b01);
        txn(1'b0, 2'd0, 1'b1, 32'h83, 32'h0);
        chk("ldbu_rdata", t_rd, 32'h00000088);

        // half loads, both lanes
        txn(1'b0, 2'd1, 1'b0, 32'h82, 32'h0);
        chk("ldh_hi_rdata", t_rd, 32'hFFFF8899);
        txn(1'b0, 2'd1, 1'b1, 32'h80, 32'h0);
        chk("ldhu_lo_rdata", t_rd, 32'h0000AABB);

        // st.h 0x102
        txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD);
        chk("sth_en", 32'(t_en), 32'd1);
        chk("sth_we", 32'(t_we), 32'hC);
        chk("sth_wdata", t_wd, 32'hABCDABCD);
        chk("sth_addr", t_ad, 32'h100);
        chk("sth_lat", 32'(t_lat), 32'd2);
        chk("sth_rdata", t_rd, 32'h0);
        chk("sth_post", 32'(t_post), 32'b01);

        // st.b 0x101, st.w 0x44
        txn(1'b1, 2'd0, 1'b0, 32'h101, 32'h7777775A);
        chk("stb_we", 32'(t_we), 32'h2);
        chk("stb_wdata", t_wd, 32'h5A5A5A5A);
        txn(1'b1, 2'd2, 1'b0, 32'h44, 32'hCAFEF00D);
        chk("stw_we", 32'(t_we), 32'hF);
        chk("stw_wdata", t_wd, 32'hCAFEF00D);
        chk("stw_addr", t_ad, 32'h44);

        // back-pressure: ld.w 0x40 with resp_ready low, second request pending
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_unsign = 1'b0; bus.req_addr = 32'h40;
        @(posedge clk);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.resp_valid) got = 1'b1;
        end
        chk("bp_resp_seen", 32'(got), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            bus.req_valid = 1'b1; bus.req_size = 2'd0; bus.req_addr = 32'h83;
            #1;
            chk("bp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_rdata", bus.resp_rdata, 32'hDEADBEEF);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_sram_en", 32'(en1), 32'd0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        #1;
        chk("bp_hs_req_ready", 32'(bus.req_ready), 32'd0);
        chk("bp_hs_sram_en", 32'(en1), 32'd0);
        chk("bp_hs_rdata", bus.resp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("bp_after_valid", 32'(bus.resp_valid), 32'd0);
        chk("bp_after_ready", 32'(bus.req_ready), 32'd1);
        chk("bp_after_en", 32'(en1), 32'd1);
        @(posedge clk);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.resp_valid) got = 1'b1;
        end
        chk("bp_second_seen", 32'(got), 32'd1);
        chk("bp_second_rdata", bus.resp_rdata, 32'hFFFFFF88);
        @(posedge clk);

        // reset while the load sits in WAIT; SRAM data arrives that same edge
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h80;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rmid_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rmid_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rmid_rdata", bus.resp_rdata, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rpost_valid", 32'(bus.resp_valid), 32'd0);
            chk("rpost_rdata", bus.resp_rdata, 32'd0);
        end

        // latency sweep: ld.hu 0x12 on all three instances at once
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd1;
        bus.req_unsign = 1'b1; bus.req_addr = 32'h12;
        bus2.req_valid = 1'b1; bus3.req_valid = 1'b1;
        @(posedge clk);
        l1 = 0; l2 = 0; l3 = 0; s1 = '0; s2 = '0; s3 = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0; bus2.req_valid = 1'b0; bus3.req_valid = 1'b0;
            if (bus.resp_valid  && l1 == 0) begin l1 = i; s1 = bus.resp_rdata;  end
            if (bus2.resp_valid && l2 == 0) begin l2 = i; s2 = bus2.resp_rdata; end
            if (bus3.resp_valid && l3 == 0) begin l3 = i; s3 = bus3.resp_rdata; end
        end
        chk("sweep_lat1", 32'(l1), 32'd2);
        chk("sweep_lat2", 32'(l2), 32'd3);
        chk("sweep_lat3", 32'(l3), 32'd4);
        chk("sweep_rd1", s1, 32'h0000F00D);
        chk("sweep_rd2", s2, 32'h0000F00D);
        chk("sweep_rd3", s3, 32'h0000F00D);

        // ld.w at 0x41
        txn(1'b0, 2'd2, 1'b0, 32'h41, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_en", 32'(t_en), 32'd0);
        chk("mis_err", 32'(t_err), 32'd1);
        chk("mis_rdata", t_rd, 32'h0);
        chk("mis_lat", 32'(t_lat), 32'd1);
`else
        chk("mis_en", 32'(t_en), 32'd1);
        chk("mis_addr", t_ad, 32'h40);
        chk("mis_err", 32'(t_err), 32'd0);
        chk("mis_rdata", t_rd, 32'hDEADBEEF);
`endif
        chk("mis_post", 32'(t_post), 32'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
